s641_misr_compactor: RTL
========================

# s641_misr_compactor

Response compactor that sits directly downstream of the s641 core. It folds the core's 24 primary outputs into a 24-bit multiple-input signature register (MISR) over a programmable number of valid capture cycles. When the window closes it reports the final signature and a pass/fail compare against an expected value. It is used by the s641 test harness to reduce a long output stream to one word per run.

## Interface
- WIDTH, 24, response/signature width; equals the s641 output count.
- CNT_W, 16, width of the capture-length counter.
- SEED, 24'h000001, MISR value loaded on START.

- CK  input  1  rising-edge clock, same clock as the s641 flip-flops.
- RN  input  1  reset, asynchronous, active-low.
- START  input  1  begin a capture window; sampled on the CK rising edge.
- LEN  input  CNT_W  number of valid samples to compact; sampled with START.
- D  input  WIDTH  s641 outputs. Bit order: D[23]=G91, D[22]=G94, D[21]=G107, D[20]=G83, D[19]=G84, D[18]=G85, D[17]=G100BF, D[16]=G98BF, D[15]=G96BF, D[14]=G92, D[13]=G87BF, D[12]=G89BF, D[11]=G101BF, D[10]=G106BF, D[9]=G97BF, D[8]=G104BF, D[7]=G88BF, D[6]=G99BF, D[5]=G105BF, D[4]=G138, D[3]=G86BF, D[2]=G95BF, D[1]=G103BF, D[0]=G90.
- D_VALID  input  1  D is a sample to compact this cycle.
- EXP_SIG  input  WIDTH  expected signature; must be stable while BUSY is high.
- BUSY  output  1  high while in the RUN state.
- DONE  output  1  window complete; held high until the next START or reset.
- PASS  output  1  SIG equals EXP_SIG; valid only while DONE is high, otherwise 0.
- SIG  output  WIDTH  current MISR contents.

## Operation
- States: IDLE, RUN, DONE. All registers reset asynchronously when RN=0.
- Reset values:
  - state = IDLE
  - SIG = 0, count = 0
  - BUSY = 0, DONE = 0, PASS = 0
- MISR update, applied only on a RUN edge with D_VALID=1:
  - fb = SIG[23]^SIG[22]^SIG[21]^SIG[16]
  - SIG_next = {SIG[22:0], fb} ^ D
  - Polynomial is x^24+x^23+x^22+x^17+1. All arithmetic is on WIDTH bits with no carries.
- IDLE:
  - START=1 loads SIG=SEED and count=LEN.
  - If LEN≠0, go to RUN. If LEN=0, go directly to DONE with PASS=(SEED==EXP_SIG).
- RUN:
  - Each D_VALID=1 edge updates SIG and decrements count.
  - D_VALID=0 holds SIG and count.
  - On the edge that absorbs the sample with count==1, go to DONE and register PASS=(SIG_next==EXP_SIG).
  - START is ignored in RUN.
- DONE:
  - SIG, PASS and DONE are frozen.
  - START behaves exactly as in IDLE: reload and start a new window; DONE and PASS clear on that edge.
  - D_VALID is ignored.
- Reset asserted mid-run aborts immediately to the reset values. No partial signature is retained.

## Timing
- START edge k: BUSY=1 from cycle k+1. The first sample that can be compacted is the one presented at edge k+1.
- The START-edge D is never compacted.
- Latency: DONE and PASS become visible in the cycle after the edge that absorbed the LEN-th valid sample. BUSY falls in that same cycle.
- With continuous D_VALID, DONE rises LEN+1 cycles after the START edge. For LEN=0, DONE rises 1 cycle after the START edge.
- SIG is visible one cycle after each absorbing edge.
- EXP_SIG is sampled only on the final absorbing edge (or on the START edge when LEN=0).
- LEN = 2^CNT_W−1 is legal. The counter never wraps because it stops at 0.

## Test plan
- Reset then idle: RN low, then high for 5 cycles with no START → SIG=0, BUSY=0, DONE=0, PASS=0.
- SEED=1, START with LEN=1, EXP_SIG=0x000002, D=0 with D_VALID=1 at the next edge → SIG=0x000002, DONE=1 and PASS=1 two cycles after START.
- Seed 0x800000 (feedback path), LEN=1, D=0 → SIG=0x000001. With D=0xFFFFFF and SEED=1 instead → SIG=0xFFFFFD; EXP_SIG=0 gives PASS=0.
- LEN=2, D=0, with D_VALID pattern 1,0,0,1 → SIG stays 0x000002 during the gap and ends at 0x000004. DONE rises 5 cycles after START.
- LEN=0 → DONE one cycle after START, SIG=SEED. START during RUN (LEN=3) is ignored: DONE only after 3 valid samples.
- RN pulsed low mid-RUN → all outputs 0 immediately. A new START/LEN=1 then completes normally.

Source files
------------

// File: rtl/s641_misr_compactor_if.sv
// Handshake/bus bundle between the s641 test harness and the MISR response compactor.
// The harness drives the master side; the compactor implements the slave side.
interface s641_misr_compactor_if #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 16
);
    logic             START;
    logic [CNT_W-1:0] LEN;
    logic [WIDTH-1:0] D;
    logic             D_VALID;
    logic [WIDTH-1:0] EXP_SIG;
    logic             BUSY;
    logic             DONE;
    logic             PASS;
    logic [WIDTH-1:0] SIG;

    modport master (
        output START, LEN, D, D_VALID, EXP_SIG,
        input  BUSY, DONE, PASS, SIG
    );

    modport slave (
        input  START, LEN, D, D_VALID, EXP_SIG,
        output BUSY, DONE, PASS, SIG
    );
endinterface

// File: rtl/s641_misr_compactor.sv
// Folds the 24 s641 primary outputs into a 24-bit MISR over LEN valid samples,
// then holds the final signature and its compare against EXP_SIG until the next START.
module s641_misr_compactor #(
    parameter int               WIDTH = 24,
    parameter int               CNT_W = 16,
    parameter logic [WIDTH-1:0] SEED  = 24'h000001
) (
    input  logic                  CK,
    input  logic                  RN,
    s641_misr_compactor_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic [WIDTH-1:0] sig_nxt;

    // Polynomial x^24+x^23+x^22+x^17+1: taps at bits 23, 22, 21 and 16.
    function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] d);
        logic fb;
        fb = s[23] ^ s[22] ^ s[21] ^ s[16];
        return {s[WIDTH-2:0], fb} ^ d;
    endfunction

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        sig_nxt = misr_step(sig_q, bus.D);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE restarts exactly like IDLE; D_VALID has no effect here.
                if (bus.START) begin
                    sig_d = SEED;
                    cnt_d = bus.LEN;
                    if (bus.LEN != '0) begin
                        state_d = ST_RUN;
                        pass_d  = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                        pass_d  = (SEED == bus.EXP_SIG);
                    end
                end
            end
            ST_RUN: begin
                if (bus.D_VALID) begin
                    sig_d = sig_nxt;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                        pass_d  = (sig_nxt == bus.EXP_SIG);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pass_d  = 1'b0;
            end
        endcase
    end

    assign bus.BUSY = (state_q == ST_RUN);
    assign bus.DONE = (state_q == ST_DONE);
    assign bus.PASS = pass_q & (state_q == ST_DONE);
    assign bus.SIG  = sig_q;

endmodule
